// File: rtl/soc_ledkey_mmio_if.sv
// Data-bus port bundle between the SoC initiator and a memory-mapped responder.
// The initiator drives the request; the responder answers with a done pulse and read data.
interface soc_ledkey_mmio_if;
  logic        mem_valid;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic        mem_wstrobe;
  logic [31:0] mem_rdata;
  logic        mem_done;

  modport master (
    output mem_valid, mem_addr, mem_wdata, mem_wstrobe,
    input  mem_rdata, mem_done
  );

  modport slave (
    input  mem_valid, mem_addr, mem_wdata, mem_wstrobe,
    output mem_rdata, mem_done
  );
endinterface

// File: rtl/soc_ledkey_mmio.sv
// iceFUN LED-matrix / key responder: four LED row registers, debounced keys with sticky
// press flags, and an autonomous column scanner driven by a programmable divider.
module soc_ledkey_mmio #(
  parameter int DEBOUNCE_CYCLES = 12000,
  parameter int SCAN_DIV_RESET  = 3000,
  parameter bit KEY_ACTIVE_LOW  = 1'b1
) (
  input  logic                    clk,
  input  logic                    rst,
  soc_ledkey_mmio_if.slave        bus,
  input  logic [3:0]              keys,
  output logic [7:0]              leds,
  output logic [3:0]              lcol
);
  localparam int          DB_W     = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [31:0] ID_VALUE = 32'h4C45_444B;

  typedef enum logic {IDLE, ACK} state_t;

  state_t      state_reg, state_next;
  logic [2:0]  addr_reg, addr_next;
  logic [15:0] wdata_reg, wdata_next;
  logic        wr_reg, wr_next;

  logic [7:0]  led_row_reg [4];
  logic [3:0]  keypress_reg;
  logic [15:0] scandiv_reg;
  logic [15:0] scan_cnt_reg;
  logic [1:0]  col_reg;
  logic [3:0]  lcol_reg;
  logic [7:0]  leds_reg;

  logic [3:0]  key_state;
  logic [3:0]  key_rise;
  logic [3:0]  kp_clear;
  logic        wr_en;
  logic [31:0] rd_word;

  // Only the word index and the low half of write data are ever used.
  logic unused_bus_bits;
  assign unused_bus_bits = ^{bus.mem_addr[31:5], bus.mem_addr[1:0], bus.mem_wdata[31:16]};

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg <= IDLE;
      addr_reg  <= '0;
      wdata_reg <= '0;
      wr_reg    <= 1'b0;
    end else begin
      state_reg <= state_next;
      addr_reg  <= addr_next;
      wdata_reg <= wdata_next;
      wr_reg    <= wr_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    addr_next  = addr_reg;
    wdata_next = wdata_reg;
    wr_next    = wr_reg;
    case (state_reg)
      IDLE: begin
        if (bus.mem_valid) begin
          state_next = ACK;
          addr_next  = bus.mem_addr[4:2];
          wdata_next = bus.mem_wdata[15:0];
          wr_next    = bus.mem_wstrobe;
        end
      end
      ACK:     state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Reset asserted during ACK suppresses the pulse as well as the write.
  always_comb begin
    bus.mem_done  = 1'b0;
    bus.mem_rdata = '0;
    if (state_reg == ACK && !rst) begin
      bus.mem_done  = 1'b1;
      bus.mem_rdata = rd_word;
    end
  end

  assign wr_en = (state_reg == ACK) && wr_reg;

  always_comb begin
    rd_word = '0;
    case (addr_reg)
      3'd0, 3'd1, 3'd2, 3'd3: rd_word = {24'b0, led_row_reg[addr_reg[1:0]]};
      3'd4:                   rd_word = {28'b0, key_state};
      3'd5:                   rd_word = {28'b0, keypress_reg};
      3'd6:                   rd_word = {16'b0, scandiv_reg};
      default:                rd_word = ID_VALUE;
    endcase
  end

  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_key
      logic [1:0]      key_sync_reg;
      logic [DB_W-1:0] db_cnt_reg;
      logic            db_state_reg;
      logic            key_level;
      logic            db_done;

      assign key_level = key_sync_reg[1] ^ KEY_ACTIVE_LOW;
      assign db_done   = (db_cnt_reg == DB_W'(DEBOUNCE_CYCLES - 1));

      always_ff @(posedge clk) begin
        if (rst) begin
          key_sync_reg <= {2{KEY_ACTIVE_LOW}};
          db_cnt_reg   <= '0;
          db_state_reg <= 1'b0;
        end else begin
          key_sync_reg <= {key_sync_reg[0], keys[gi]};
          if (key_level == db_state_reg) begin
            db_cnt_reg <= '0;
          end else if (db_done) begin
            db_state_reg <= key_level;
            db_cnt_reg   <= '0;
          end else begin
            db_cnt_reg <= db_cnt_reg + DB_W'(1);
          end
        end
      end

      assign key_state[gi] = db_state_reg;
      assign key_rise[gi]  = key_level && !db_state_reg && db_done;
    end
  endgenerate

  // A press arriving on the same edge as a clear keeps the flag set.
  assign kp_clear = (wr_en && addr_reg == 3'd5) ? wdata_reg[3:0] : 4'b0;

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < 4; i++) led_row_reg[i] <= '0;
      keypress_reg <= '0;
      scandiv_reg  <= 16'(SCAN_DIV_RESET);
    end else begin
      if (wr_en && !addr_reg[2]) led_row_reg[addr_reg[1:0]] <= wdata_reg[7:0];
      if (wr_en && addr_reg == 3'd6) scandiv_reg <= wdata_reg;
      keypress_reg <= (keypress_reg & ~kp_clear) | key_rise;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      scan_cnt_reg <= 16'(SCAN_DIV_RESET);
      col_reg      <= '0;
      lcol_reg     <= 4'b1110;
      leds_reg     <= 8'hFF;
    end else begin
      if (scan_cnt_reg == 16'd0) begin
        scan_cnt_reg <= scandiv_reg;
        col_reg      <= col_reg + 2'd1;
      end else begin
        scan_cnt_reg <= scan_cnt_reg - 16'd1;
      end
      lcol_reg <= ~(4'b0001 << col_reg);
      leds_reg <= ~led_row_reg[col_reg];
    end
  end

  assign lcol = lcol_reg;
  assign leds = leds_reg;
endmodule

// File: tb/tb_soc_ledkey_mmio.sv
// Self-checking bench for soc_ledkey_mmio: register table, scan sequencing, key debounce
// corner cases, bus timing, reset abort, and randomized keys/registers against a model.
module tb_soc_ledkey_mmio;
  localparam int          DB  = 8;
  localparam int          SDR = 20;
  localparam logic [31:0] ID  = 32'h4C45_444B;

  logic       clk = 1'b0;
  logic       rst;
  logic [3:0] keys;
  logic [7:0] leds;
  logic [3:0] lcol;

  soc_ledkey_mmio_if bus();

  soc_ledkey_mmio #(
    .DEBOUNCE_CYCLES(DB),
    .SCAN_DIV_RESET (SDR),
    .KEY_ACTIVE_LOW (1'b1)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave),
    .keys(keys),
    .leds(leds),
    .lcol(lcol)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  logic [7:0]  row_m [4];
  logic [15:0] scandiv_m;
  logic [3:0]  kstate_m, kpress_m;
  logic [3:0]  pin_q[$];
  logic [3:0]  in_q[$];

  typedef struct {
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        wr;
    logic [31:0] exp;
  } vec_t;
  vec_t vecs[20];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic bus_op(input logic [31:0] addr, input logic [31:0] wdata, input logic wr,
                        output logic [31:0] rdata);
    @(negedge clk);
    bus.mem_valid = 1'b1; bus.mem_addr = addr; bus.mem_wdata = wdata; bus.mem_wstrobe = wr;
    @(negedge clk);
    check("done_latency", {31'b0, bus.mem_done}, 32'd1);
    rdata = bus.mem_rdata;
    bus.mem_valid = 1'b0;
    $display("bus %s idx=%0d wdata=%h rdata=%h", wr ? "WR" : "RD", addr[4:2], wdata, rdata);
    @(negedge clk);
  endtask

  task automatic rd_check(input string name, input logic [31:0] addr, input logic [31:0] exp);
    logic [31:0] r;
    bus_op(addr, 32'h0, 1'b0, r);
    check(name, r, exp);
  endtask

  task automatic wr(input logic [31:0] addr, input logic [31:0] wdata);
    logic [31:0] r;
    bus_op(addr, wdata, 1'b1, r);
  endtask

  task automatic model_reset();
    for (int i = 0; i < 4; i++) row_m[i] = 8'h00;
    scandiv_m = 16'(SDR);
    kstate_m = 4'h0; kpress_m = 4'h0;
    pin_q.delete(); in_q.delete();
    for (int i = 0; i < 3; i++) pin_q.push_back(4'hF);
  endtask

  // Key model: the synchronised level is the pin two edges back; a key adopts a new level
  // once its last DB synchronised samples all disagree with the current debounced state.
  task automatic model_step();
    logic [3:0] in_v;
    bit all_diff;
    pin_q.push_back(keys);
    if (pin_q.size() > 3) void'(pin_q.pop_front());
    in_v = ~pin_q[0];
    in_q.push_back(in_v);
    if (in_q.size() > DB) void'(in_q.pop_front());
    for (int k = 0; k < 4; k++) begin
      all_diff = (in_q.size() == DB);
      foreach (in_q[j]) if (in_q[j][k] == kstate_m[k]) all_diff = 1'b0;
      if (all_diff) begin
        kstate_m[k] = in_v[k];
        if (in_v[k]) kpress_m[k] = 1'b1;
      end
    end
  endtask

  function automatic int col_of(input logic [3:0] lc);
    int c = 0;
    for (int i = 0; i < 4; i++) if (!lc[i]) c = i;
    return c;
  endfunction

  function automatic logic [31:0] exp_reg(input int idx);
    case (idx)
      0, 1, 2, 3: return {24'b0, row_m[idx]};
      4:          return {28'b0, kstate_m};
      5:          return {28'b0, kpress_m};
      6:          return {16'b0, scandiv_m};
      default:    return ID;
    endcase
  endfunction

  initial begin
    logic [31:0] r, tmp, addr;
    logic [7:0]  e8;
    logic [3:0]  prev;
    int          run, changes, runs[4], idx;
    bit          found, exp_done;

    rst = 1'b1; keys = 4'hF;
    bus.mem_valid = 1'b0; bus.mem_addr = '0; bus.mem_wdata = '0; bus.mem_wstrobe = 1'b0;
    model_reset();
    repeat (3) @(negedge clk);
    check("rst_lcol", {28'b0, lcol}, 32'hE);
    check("rst_leds", {24'b0, leds}, 32'hFF);
    check("rst_done", {31'b0, bus.mem_done}, 32'd0);
    check("rst_rdata", bus.mem_rdata, 32'd0);
    rst = 1'b0;
    @(negedge clk);

    // Register map table, starting from reset values.
    vecs[0]  = '{32'h00, 32'h0, 1'b0, 32'h0};
    vecs[1]  = '{32'h04, 32'h0, 1'b0, 32'h0};
    vecs[2]  = '{32'h08, 32'h0, 1'b0, 32'h0};
    vecs[3]  = '{32'h0C, 32'h0, 1'b0, 32'h0};
    vecs[4]  = '{32'h10, 32'h0, 1'b0, 32'h0};
    vecs[5]  = '{32'h14, 32'h0, 1'b0, 32'h0};
    vecs[6]  = '{32'h18, 32'h0, 1'b0, 32'(SDR)};
    vecs[7]  = '{32'h1C, 32'h0, 1'b0, ID};
    vecs[8]  = '{32'h04, 32'hFFFF_FF3C, 1'b1, 32'h0};
    vecs[9]  = '{32'h04, 32'h0, 1'b0, 32'h3C};
    vecs[10] = '{32'h1C, 32'h0, 1'b1, 32'h0};
    vecs[11] = '{32'h1C, 32'h0, 1'b0, ID};
    vecs[12] = '{32'h10, 32'hF, 1'b1, 32'h0};
    vecs[13] = '{32'h10, 32'h0, 1'b0, 32'h0};
    vecs[14] = '{32'h18, 32'hFFFF_0003, 1'b1, 32'h0};
    vecs[15] = '{32'h18, 32'h0, 1'b0, 32'h3};
    vecs[16] = '{32'hFFFF_FFE4, 32'h0, 1'b0, 32'h3C};
    vecs[17] = '{32'h00, 32'h81, 1'b1, 32'h0};
    vecs[18] = '{32'h20, 32'h0, 1'b0, 32'h81};
    vecs[19] = '{32'h14, 32'hF, 1'b1, 32'h0};
    foreach (vecs[i]) begin
      bus_op(vecs[i].addr, vecs[i].wdata, vecs[i].wr, r);
      if (!vecs[i].wr) check($sformatf("table_%0d", i), r, vecs[i].exp);
    end
    row_m[0] = 8'h81; row_m[1] = 8'h3C; scandiv_m = 16'd3;

    // LEDS2 pattern shows up inverted when column 2 is driven.
    wr(32'h08, 32'hA5); row_m[2] = 8'hA5;
    rd_check("leds2_read", 32'h08, 32'hA5);
    found = 1'b0;
    for (int c = 0; c < 60 && !found; c++) begin
      @(negedge clk);
      if (lcol == 4'b1011) found = 1'b1;
    end
    if (found) check("col2_leds", {24'b0, leds}, 32'h5A);
    else begin n_checks++; n_errors++; $display("FAIL col2_timeout: got none required lcol=1011"); end

    // Scan period with SCANDIV=3 and column rotation/wrap.
    repeat (10) @(negedge clk);
    prev = lcol; run = 0; changes = 0;
    for (int c = 0; c < 120 && changes < 9; c++) begin
      @(negedge clk);
      e8 = ~row_m[col_of(lcol)];
      check("scan_leds", {24'b0, leds}, {24'b0, e8});
      if (lcol !== prev) begin
        check("scan_next", {28'b0, lcol}, {28'b0, prev[2:0], prev[3]});
        if (changes > 0) check("scan_period", run, 32'd4);
        prev = lcol; run = 1; changes++;
      end else run++;
    end
    if (changes < 9) begin n_checks++; n_errors++; $display("FAIL scan_timeout: got %0d changes required 9", changes); end
    rd_check("id_read", 32'h1C, ID);

    // Key0 press held DB+2 cycles, then a short glitch on key1.
    keys[0] = 1'b0;
    repeat (DB + 2) @(negedge clk);
    repeat (2) @(negedge clk);
    rd_check("key_state_pressed", 32'h10, 32'h1);
    rd_check("key_press_flag", 32'h14, 32'h1);
    keys[1] = 1'b0;
    repeat (DB - 1) @(negedge clk);
    keys[1] = 1'b1;
    repeat (14) @(negedge clk);
    rd_check("glitch_state", 32'h10, 32'h1);
    rd_check("glitch_press", 32'h14, 32'h1);

    // Release key0, clear its flag, then race a clear against a new press.
    keys[0] = 1'b1;
    repeat (14) @(negedge clk);
    rd_check("key_released", 32'h10, 32'h0);
    rd_check("press_sticky", 32'h14, 32'h1);
    wr(32'h14, 32'h1);
    rd_check("press_cleared", 32'h14, 32'h0);
    @(negedge clk);
    keys[0] = 1'b0;
    repeat (DB) @(negedge clk);
    bus.mem_valid = 1'b1; bus.mem_addr = 32'h14; bus.mem_wdata = 32'h1; bus.mem_wstrobe = 1'b1;
    @(negedge clk);
    check("race_done", {31'b0, bus.mem_done}, 32'd1);
    bus.mem_valid = 1'b0;
    @(negedge clk);
    rd_check("race_set_wins", 32'h14, 32'h1);
    rd_check("race_state", 32'h10, 32'h1);
    wr(32'h14, 32'h1);
    rd_check("w1c_after", 32'h14, 32'h0);
    keys[0] = 1'b1;
    repeat (14) @(negedge clk);

    // mem_valid held for four cycles: done on cycles 2 and 4 only.
    @(negedge clk);
    bus.mem_valid = 1'b1; bus.mem_addr = 32'h1C; bus.mem_wstrobe = 1'b0;
    for (int c = 1; c <= 4; c++) begin
      if (c > 1) @(negedge clk);
      exp_done = (c == 2 || c == 4);
      check($sformatf("hold_done_%0d", c), {31'b0, bus.mem_done}, {31'b0, exp_done});
      check($sformatf("hold_rdata_%0d", c), bus.mem_rdata, exp_done ? ID : 32'h0);
    end
    bus.mem_valid = 1'b0;
    @(negedge clk);
    check("hold_idle_done", {31'b0, bus.mem_done}, 32'd0);

    // Reset during the ACK of a LEDS0 write.
    bus.mem_valid = 1'b1; bus.mem_addr = 32'h00; bus.mem_wdata = 32'h77; bus.mem_wstrobe = 1'b1;
    @(negedge clk);
    rst = 1'b1; bus.mem_valid = 1'b0;
    #1;
    check("abort_no_done", {31'b0, bus.mem_done}, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    model_reset();
    check("abort_lcol", {28'b0, lcol}, 32'hE);
    check("abort_leds", {24'b0, leds}, 32'hFF);
    check("abort_done_after", {31'b0, bus.mem_done}, 32'd0);
    rd_check("abort_leds0", 32'h00, 32'h0);

    // Randomized key activity against the windowed debounce model.
    for (int k = 0; k < 4; k++) runs[k] = $urandom_range(1, 14);
    for (int round = 0; round < 3; round++) begin
      for (int c = 0; c < 300; c++) begin
        @(negedge clk);
        for (int k = 0; k < 4; k++) begin
          if (runs[k] == 0) begin
            keys[k] = ~keys[k];
            runs[k] = $urandom_range(1, 14);
          end
          runs[k]--;
        end
        model_step();
      end
      for (int c = 0; c < 14; c++) begin
        @(negedge clk);
        model_step();
      end
      rd_check($sformatf("rand_keystate_%0d", round), 32'h10, {28'b0, kstate_m});
      rd_check($sformatf("rand_keypress_%0d", round), 32'h14, {28'b0, kpress_m});
      wr(32'h14, 32'hF);
      kpress_m = 4'h0;
    end

    // Randomized register traffic with junk in the undecoded address bits.
    for (int n = 0; n < 40; n++) begin
      idx = $urandom_range(0, 7);
      tmp = $urandom();
      addr = {tmp[31:5], 3'(idx), tmp[1:0]};
      if ($urandom_range(0, 1) == 1) begin
        tmp = $urandom();
        wr(addr, tmp);
        if (idx < 4) row_m[idx] = tmp[7:0];
        else if (idx == 5) kpress_m = kpress_m & ~tmp[3:0];
        else if (idx == 6) scandiv_m = tmp[15:0];
      end else begin
        rd_check($sformatf("rand_reg_%0d", idx), addr, exp_reg(idx));
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
